// File: rtl/game_pkg.sv
// Shared encodings and widths for the frog game-flow controller.
package game_pkg;

  localparam int LEVEL_W = 5;
  localparam int LIVES_W = 2;
  localparam int SPEED_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_HIT       = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // Car speed tier: one step every four levels, capped at the top tier.
  function automatic logic [SPEED_W-1:0] speed_tier(input logic [LEVEL_W-1:0] level);
    logic [LEVEL_W-1:0] tier;
    tier = level >> 2;
    return (tier > LEVEL_W'(7)) ? SPEED_W'(7) : tier[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame-tick counter shared by the timed phases; done fires on the tick that
// would move the count past limit.
module frame_timer #(
  parameter int N = 60,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         done
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign done = en && (count == limit);

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences play, death, level-up and game-over phases
// and owns level/lives bookkeeping for the frog game.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int MAX_LEVEL      = 31,
  parameter int HIT_FRAMES     = 60,
  parameter int LEVELUP_FRAMES = 30,
  parameter int FLASH_FRAMES   = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Frame_Tick,
  input  logic               i_Start,
  input  logic               i_Collision,
  input  logic               i_Frog_At_Top,
  output logic [2:0]         o_State,
  output logic               o_Reset_Frog,
  output logic               o_Cars_Run,
  output logic [LEVEL_W-1:0] o_Level,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [SPEED_W-1:0] o_Speed_Sel,
  output logic               o_Flash,
  output logic               o_Game_Over
);

  localparam int CNT_N = (HIT_FRAMES > LEVELUP_FRAMES) ? HIT_FRAMES : LEVELUP_FRAMES;
  localparam int CNT_W = (CNT_N > 1) ? $clog2(CNT_N) : 1;
  localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] LU_LAST  = CNT_W'(LEVELUP_FRAMES - 1);

  state_t             state, state_d;
  logic               start_prev, start_edge;
  logic               timer_clear, timer_done;
  logic [CNT_W-1:0]   frame_cnt, timer_limit;
  logic [CNT_W:0]     cnt_inc;
  logic [LEVEL_W-1:0] level_d;
  logic [LIVES_W-1:0] lives_d;
  logic               reset_frog_d, flash_d, cars_run_d, game_over_d;

  assign start_edge = i_Start & ~start_prev;
  assign cnt_inc    = {1'b0, frame_cnt} + 1'b1;
  // Counter is held at zero outside timed phases and on every transition, so
  // a tick coincident with state entry is never counted.
  assign timer_clear = (state != ST_HIT && state != ST_LEVEL_UP) || (state_d != state);

  frame_timer #(.N(CNT_N)) u_timer (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .clear (timer_clear),
    .en    (i_Frame_Tick),
    .limit (timer_limit),
    .count (frame_cnt),
    .done  (timer_done)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= ST_IDLE;
      start_prev <= 1'b0;
    end else begin
      state      <= state_d;
      start_prev <= i_Start;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    timer_limit = HIT_LAST;
    case (state)
      ST_IDLE, ST_GAME_OVER: if (start_edge) state_d = ST_PLAY;
      ST_PLAY: begin
        if (i_Collision)        state_d = ST_HIT;
        else if (i_Frog_At_Top) state_d = ST_LEVEL_UP;
      end
      ST_HIT:
        if (timer_done) state_d = (o_Lives == '0) ? ST_GAME_OVER : ST_PLAY;
      ST_LEVEL_UP: begin
        timer_limit = LU_LAST;
        if (timer_done) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d      = o_Level;
    lives_d      = o_Lives;
    reset_frog_d = 1'b0;
    flash_d      = 1'b0;
    case (state)
      ST_IDLE, ST_GAME_OVER:
        if (start_edge) begin
          level_d      = LEVEL_W'(1);
          lives_d      = LIVES_W'(LIVES_INIT);
          reset_frog_d = 1'b1;
        end
      ST_PLAY: begin
        if (i_Collision) begin
          if (o_Lives != '0) lives_d = o_Lives - 1'b1;
        end else if (i_Frog_At_Top) begin
          if (o_Level < LEVEL_W'(MAX_LEVEL)) level_d = o_Level + 1'b1;
        end else if (start_edge) begin
          level_d      = LEVEL_W'(1);
          lives_d      = LIVES_W'(LIVES_INIT);
          reset_frog_d = 1'b1;
        end
      end
      ST_HIT: begin
        flash_d = o_Flash;
        if (timer_done) begin
          flash_d      = 1'b0;
          reset_frog_d = (o_Lives != '0);
        end else if (i_Frame_Tick && ((int'(cnt_inc) % FLASH_FRAMES) == 0)) begin
          flash_d = ~o_Flash;
        end
      end
      ST_LEVEL_UP: reset_frog_d = timer_done;
      default: ;
    endcase
    cars_run_d  = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Level      <= LEVEL_W'(1);
      o_Lives      <= LIVES_W'(LIVES_INIT);
      o_Reset_Frog <= 1'b0;
      o_Cars_Run   <= 1'b0;
      o_Flash      <= 1'b0;
      o_Game_Over  <= 1'b0;
      o_Speed_Sel  <= '0;
    end else begin
      o_Level      <= level_d;
      o_Lives      <= lives_d;
      o_Reset_Frog <= reset_frog_d;
      o_Cars_Run   <= cars_run_d;
      o_Flash      <= flash_d;
      o_Game_Over  <= game_over_d;
      o_Speed_Sel  <= speed_tier(o_Level);
    end
  end

  assign o_State = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a vector table for the opening sequence
// plus hand-written multi-cycle sequences for the timed phases.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, coll = 1'b0, top = 1'b0;
  logic [2:0] state_o;
  logic       reset_frog, cars_run, flash, game_over;
  logic [4:0] level;
  logic [1:0] lives;
  logic [2:0] speed_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Frame_Tick  (tick),
    .i_Start       (start),
    .i_Collision   (coll),
    .i_Frog_At_Top (top),
    .o_State       (state_o),
    .o_Reset_Frog  (reset_frog),
    .o_Cars_Run    (cars_run),
    .o_Level       (level),
    .o_Lives       (lives),
    .o_Speed_Sel   (speed_sel),
    .o_Flash       (flash),
    .o_Game_Over   (game_over)
  );

  typedef struct {
    string name;
    logic  start, coll, top, tick;
    int    st, lvl, lives, cars, rf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int tier(input int lvl);
    return ((lvl >> 2) > 7) ? 7 : (lvl >> 2);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_level"}, level, 1);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_rf"}, reset_frog, 0);
    check({tag, "_cars"}, cars_run, 0);
    check({tag, "_flash"}, flash, 0);
    check({tag, "_speed"}, speed_sel, 0);
    check({tag, "_gameover"}, game_over, 0);
  endtask

  // One death: collision edge, then 60 ticks with flash tracked per tick.
  task automatic do_hit(input int exp_lives, input int exp_level);
    int exp_flash;
    coll = 1'b1;
    step();
    coll = 1'b0;
    check("hit_entry_state", state_o, 2);
    check("hit_entry_lives", lives, exp_lives);
    check("hit_entry_level", level, exp_level);
    check("hit_entry_cars", cars_run, 0);
    tick = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      coll = (t >= 10 && t <= 20);
      step();
      if (t < 60) begin
        exp_flash = (t / 8) % 2;
        check("hit_flash", flash, exp_flash);
        check("hit_hold_state", state_o, 2);
        check("hit_hold_lives", lives, exp_lives);
      end
    end
    coll = 1'b0;
    tick = 1'b0;
    check("hit_exit_flash", flash, 0);
    check("hit_exit_level", level, exp_level);
    if (exp_lives == 0) begin
      check("hit_exit_state", state_o, 4);
      check("hit_exit_gameover", game_over, 1);
      check("hit_exit_rf", reset_frog, 0);
      check("hit_exit_cars", cars_run, 0);
    end else begin
      check("hit_exit_state", state_o, 1);
      check("hit_exit_rf", reset_frog, 1);
      check("hit_exit_cars", cars_run, 1);
      step();
      check("hit_rf_one_cycle", reset_frog, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lvl, old_lvl;

    vecs[0] = '{"idle",          0, 0, 0, 0, 0, 1, 3, 0, 0};
    vecs[1] = '{"start",         1, 0, 0, 0, 1, 1, 3, 1, 1};
    vecs[2] = '{"start_held",    1, 0, 0, 0, 1, 1, 3, 1, 0};
    vecs[3] = '{"start_low",     0, 0, 0, 0, 1, 1, 3, 1, 0};
    vecs[4] = '{"goal_entry",    0, 0, 1, 1, 3, 2, 3, 0, 0};
    vecs[5] = '{"lu_tick1",      0, 0, 0, 1, 3, 2, 3, 0, 0};
    vecs[6] = '{"lu_coll_ignor", 0, 1, 0, 1, 3, 2, 3, 0, 0};

    step();
    step();
    check_reset_values("rst");
    rst_n = 1'b1;

    // Table: start game, held start, goal reached (entry tick not counted).
    foreach (vecs[i]) begin
      start = vecs[i].start;
      coll  = vecs[i].coll;
      top   = vecs[i].top;
      tick  = vecs[i].tick;
      step();
      check({vecs[i].name, "_state"}, state_o, vecs[i].st);
      check({vecs[i].name, "_level"}, level, vecs[i].lvl);
      check({vecs[i].name, "_lives"}, lives, vecs[i].lives);
      check({vecs[i].name, "_cars"}, cars_run, vecs[i].cars);
      check({vecs[i].name, "_rf"}, reset_frog, vecs[i].rf);
    end
    coll = 1'b0;

    // Two ticks counted so far; 27 more keep LEVEL_UP, the 30th exits.
    for (int t = 3; t <= 29; t++) step();
    check("lu_tick29_state", state_o, 3);
    step();
    tick = 1'b0;
    check("lu_exit_state", state_o, 1);
    check("lu_exit_rf", reset_frog, 1);
    check("lu_exit_cars", cars_run, 1);
    check("lu_exit_level", level, 2);
    step();
    check("lu_rf_one_cycle", reset_frog, 0);

    // Three deaths: lives 2, 1, 0; the last ends in GAME_OVER with level held.
    do_hit(2, 2);
    do_hit(1, 2);
    do_hit(0, 2);
    step();
    check("go_hold_state", state_o, 4);
    check("go_hold_level", level, 2);
    check("go_hold_lives", lives, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("go_restart_state", state_o, 1);
    check("go_restart_level", level, 1);
    check("go_restart_lives", lives, 3);
    check("go_restart_rf", reset_frog, 1);
    check("go_restart_gameover", game_over, 0);
    step();

    // Collision and goal together: collision wins, level untouched.
    coll = 1'b1;
    top  = 1'b1;
    step();
    coll = 1'b0;
    top  = 1'b0;
    check("both_state", state_o, 2);
    check("both_level", level, 1);
    check("both_lives", lives, 2);

    // Reset at tick 20 of HIT: outputs return to reset values without an edge.
    tick = 1'b1;
    for (int t = 1; t <= 20; t++) step();
    tick = 1'b0;
    check("midhit_state", state_o, 2);
    rst_n = 1'b0;
    #2;
    check_reset_values("async_rst");
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("post_rst_rf", reset_frog, 0);
      check("post_rst_state", state_o, 0);
    end

    // 32 level-ups with start held throughout: saturation and no restart.
    start = 1'b1;
    step();
    check("sat_start_rf", reset_frog, 1);
    exp_lvl = 1;
    for (int k = 1; k <= 32; k++) begin
      old_lvl = exp_lvl;
      exp_lvl = (exp_lvl < 31) ? exp_lvl + 1 : 31;
      top = 1'b1;
      step();
      top = 1'b0;
      check("sat_entry_state", state_o, 3);
      check("sat_entry_level", level, exp_lvl);
      check("sat_speed_lag", speed_sel, tier(old_lvl));
      tick = 1'b1;
      step();
      check("sat_speed_new", speed_sel, tier(exp_lvl));
      for (int t = 2; t <= 30; t++) step();
      tick = 1'b0;
      check("sat_exit_state", state_o, 1);
      check("sat_exit_rf", reset_frog, 1);
      step();
      check("sat_no_restart_rf", reset_frog, 0);
      check("sat_no_restart_level", level, exp_lvl);
    end
    start = 1'b0;
    check("sat_final_level", level, 31);
    check("sat_final_speed", speed_sel, 7);
    check("sat_final_lives", lives, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central game-flow controller for the frog game.
- Sequences play, death, level-up and game-over phases.
- Decides when the frog is re-spawned and when cars may move.
- Owns level and lives bookkeeping, replacing the ad-hoc reset/level wiring at top level.
- Sits between the collision/frog logic, the car movers (run enable and speed select), and the level/7-segment display path.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- MAX_LEVEL, 31, level saturation value (fits 5 bits).
- HIT_FRAMES, 60, frame ticks spent in HIT before continuing.
- LEVELUP_FRAMES, 30, frame ticks spent in LEVEL_UP.
- FLASH_FRAMES, 8, frame ticks per o_Flash half-period in HIT.

Ports:
- i_Clk, in, 1, system clock.
- i_Rst_n, in, 1, asynchronous active-low reset.
- i_Frame_Tick, in, 1, one-cycle pulse per VGA frame.
- i_Start, in, 1, debounced start level (all four switches pressed).
- i_Collision, in, 1, frog/car overlap level.
- i_Frog_At_Top, in, 1, frog reached goal row (level).
- o_State, out, 3, current state encoding.
- o_Reset_Frog, out, 1, one-cycle frog respawn pulse.
- o_Cars_Run, out, 1, car movement enable.
- o_Level, out, 5, current level.
- o_Lives, out, 2, remaining lives.
- o_Speed_Sel, out, 3, car speed tier.
- o_Flash, out, 1, death blink for VGA.
- o_Game_Over, out, 1, high in GAME_OVER.

Behaviour:
- Reset values (asynchronous, while i_Rst_n=0):
  - state IDLE, o_Level=1, o_Lives=LIVES_INIT.
  - o_Reset_Frog=0, o_Cars_Run=0, o_Flash=0, o_Speed_Sel=0, o_Game_Over=0.
  - frame counter=0, start-edge register=0.
  - Reset mid-state aborts everything immediately; no pulse is emitted.
- Start edge: i_Start is registered; start_edge = i_Start & ~prev. A held switch never retriggers.
- All outputs are registered. Transitions take effect on the clock edge after the qualifying input is sampled.
- States and transitions:
  - IDLE (0): on start_edge -> PLAY. Load level=1, lives=LIVES_INIT, pulse o_Reset_Frog.
  - PLAY (1), o_Cars_Run=1:
    - i_Collision=1 -> HIT. Lives decrement on the same edge, saturating at 0. Frame counter clears.
    - else i_Frog_At_Top=1 -> LEVEL_UP. Level increments on the same edge, saturating at MAX_LEVEL. Counter clears.
    - If both are high in the same cycle, collision wins and the level is unchanged.
    - start_edge in PLAY -> restart: stay in PLAY, reload level/lives, pulse o_Reset_Frog.
  - HIT (2), o_Cars_Run=0:
    - Counter increments on i_Frame_Tick.
    - o_Flash toggles each time counter mod FLASH_FRAMES reaches 0 after an increment.
    - Exit when counter == HIT_FRAMES-1 and i_Frame_Tick=1: lives==0 -> GAME_OVER; else -> PLAY with o_Reset_Frog pulse.
    - o_Flash clears on exit.
    - i_Collision is ignored.
  - LEVEL_UP (3), o_Cars_Run=0:
    - Counts LEVELUP_FRAMES ticks, then -> PLAY with o_Reset_Frog pulse.
    - Inputs other than reset are ignored.
  - GAME_OVER (4), o_Game_Over=1, o_Cars_Run=0:
    - Level and lives hold for display.
    - start_edge -> PLAY, same as from IDLE.
- o_Reset_Frog is exactly 1 cycle, asserted in the first cycle of PLAY.
- o_Speed_Sel = min(level>>2, 7), registered, updating the cycle after the level changes.
- Frame counter width is clog2(max(HIT_FRAMES, LEVELUP_FRAMES)). It never wraps; it clears on every state entry.
- i_Frame_Tick coincident with a state-entry edge is not counted.

Decomposition:
- Shared package game_pkg:
  - State encodings ST_IDLE..ST_GAME_OVER (3-bit).
  - LEVEL_W=5, LIVES_W=2, SPEED_W=3.
- One sub-module, frame_timer:
  - Frame-tick counter with clear, enable and terminal-count output (parameter N).
  - Instantiated once and shared between HIT and LEVEL_UP.

Test Plan:
- Reset then start_edge -> o_State 0->1, o_Reset_Frog one cycle high, o_Level=1, o_Lives=3, o_Cars_Run=1.
- In PLAY, pulse i_Frog_At_Top -> o_State=3, o_Level=2, o_Cars_Run=0; after 30 frame ticks -> o_State=1 with one o_Reset_Frog pulse.
- Three collisions, each followed by 60 frame ticks:
  - o_Lives goes 2, 1, 0.
  - o_Flash toggles every 8 ticks during each HIT.
  - The third HIT ends in o_State=4 with o_Game_Over=1 and o_Level held.
- i_Collision and i_Frog_At_Top high in the same cycle -> o_State=2, o_Level unchanged, o_Lives decremented.
- Force 32 level-ups -> o_Level saturates at 31 and o_Speed_Sel=7; holding i_Start across a transition produces no second restart.
- Assert i_Rst_n=0 mid-HIT at tick 20 -> all outputs take reset values immediately; no o_Reset_Frog pulse after release.
